sram_mem_controller: RTL and testbench

Multi-cycle controller between the pipeline's memory stage and the external asynchronous SRAM. It turns single-cycle read/write requests into timed SRAM bus cycles, drives the shared data bus, and holds `ready` low while an access is in flight so the pipeline freezes. An optional one-entry write buffer lets stores retire without waiting for the SRAM.

---
 rtl/sram_ctrl_pkg.sv | 23 ++
 rtl/sram_write_buffer.sv | 31 +++
 rtl/sram_mem_controller.sv | 126 ++++++++++++
 tb/tb_sram_mem_controller.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_ctrl_pkg.sv
// Shared types, defaults and address translation for the SRAM memory controller.
package sram_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } sram_state_e;

  localparam int          DEF_ADDR_W      = 17;
  localparam int          DEF_DATA_W      = 32;
  localparam int          DEF_WAIT_CYCLES = 5;
  localparam logic [31:0] DEF_BASE_ADDR   = 32'd1024;

  // Byte address to SRAM word offset; the subtraction wraps modulo 2^32.
  function automatic logic [31:0] word_offset(input logic [31:0] byte_addr,
                                              input logic [31:0] base);
    logic [31:0] diff;
    diff = byte_addr - base;
    return {2'b00, diff[31:2]};
  endfunction

endpackage

// File: rtl/sram_write_buffer.sv
// One-entry store buffer: captures address/data on load, frees on drain_done.
module sram_write_buffer #(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              drain_done,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  output logic              full,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full <= 1'b0;
      addr <= '0;
      data <= '0;
    end else if (load && !full) begin
      full <= 1'b1;
      addr <= load_addr;
      data <= load_data;
    end else if (drain_done) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/sram_mem_controller.sv
// Pipeline-to-async-SRAM controller with timed bus cycles and a freeze (ready) signal.
// Define SRAM_CTRL_WRITE_BUFFER_EN to let stores retire through a one-entry write buffer.
module sram_mem_controller
  import sram_ctrl_pkg::*;
#(
  parameter int          ADDR_W      = DEF_ADDR_W,
  parameter int          DATA_W      = DEF_DATA_W,
  parameter int          WAIT_CYCLES = DEF_WAIT_CYCLES,
  parameter logic [31:0] BASE_ADDR   = DEF_BASE_ADDR
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [31:0]       address,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ready,
  output logic              SRAM_WE_N,
  output logic [ADDR_W-1:0] SRAM_ADDR,
  inout  wire  [DATA_W-1:0] SRAM_DQ,
  output logic [1:0]        dbg_state
);

  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  sram_state_e       state;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] addr_q;
  logic              we_n_q;
  logic              is_write;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] out_data;
  logic              req;
  logic              last_beat;
  logic              skip_done;
  logic [ADDR_W-1:0] req_word;

  assign req       = wr_en | rd_en;
  assign req_word  = ADDR_W'(word_offset(address, BASE_ADDR));
  assign last_beat = (state == S_ACCESS) && (cnt == CNT_W'(WAIT_CYCLES - 1));

`ifdef SRAM_CTRL_WRITE_BUFFER_EN
  logic              buf_full;
  logic              buf_load;
  logic [ADDR_W-1:0] buf_addr;

  // A buffered store begins draining on the same edge it is captured.
  assign buf_load  = (state == S_IDLE) && wr_en && !buf_full;
  assign skip_done = buf_full;

  sram_write_buffer #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_wbuf (
    .clk        (clk),
    .rst        (rst),
    .load       (buf_load),
    .drain_done (last_beat && buf_full),
    .load_addr  (req_word),
    .load_data  (wdata),
    .full       (buf_full),
    .addr       (buf_addr),
    .data       (out_data)
  );

  assign SRAM_ADDR = buf_full ? buf_addr : addr_q;
  assign ready     = (state == S_DONE) || ((state == S_IDLE) && (!req || buf_load));
`else
  logic [DATA_W-1:0] data_q;

  assign skip_done = 1'b0;
  assign out_data  = data_q;
  assign SRAM_ADDR = addr_q;
  assign ready     = (state == S_DONE) || ((state == S_IDLE) && !req);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      addr_q   <= '0;
      we_n_q   <= 1'b1;
      is_write <= 1'b0;
      rdata_q  <= '0;
`ifndef SRAM_CTRL_WRITE_BUFFER_EN
      data_q   <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (req) begin
            state    <= S_ACCESS;
            cnt      <= '0;
            is_write <= wr_en;
            we_n_q   <= ~wr_en;
`ifdef SRAM_CTRL_WRITE_BUFFER_EN
            if (!wr_en) addr_q <= req_word;
`else
            addr_q   <= req_word;
            data_q   <= wdata;
`endif
          end
        end
        S_ACCESS: begin
          if (last_beat) begin
            cnt    <= '0;
            we_n_q <= 1'b1;
            if (!is_write) rdata_q <= SRAM_DQ;
            state  <= skip_done ? S_IDLE : S_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign SRAM_WE_N = we_n_q;
  assign SRAM_DQ   = ((state == S_ACCESS) && is_write) ? out_data : {DATA_W{1'bz}};
  assign rdata     = rdata_q;
  assign dbg_state = state;

endmodule

// File: tb/tb_sram_mem_controller.sv
// Directed bench for sram_mem_controller: timeline-level model checked every cycle plus literal expectations.
module tb_sram_mem_controller;

  localparam int          W    = 5;
  localparam logic [31:0] SENT = 32'hA5A5_5A5A;
`ifdef SRAM_CTRL_WRITE_BUFFER_EN
  localparam bit BUF = 1'b1;
`else
  localparam bit BUF = 1'b0;
`endif
  localparam int WR_LAT = BUF ? 0 : W + 1;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic [31:0] address = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        ready;
  logic        sram_we_n;
  logic [16:0] sram_addr;
  wire  [31:0] sram_dq;
  logic [1:0]  dbg_state;

  // SRAM side of the bus: drives read data, otherwise a sentinel standing in for an idle bus.
  logic [1:0]  next_mode = 2'd0;
  logic [31:0] next_val = '0;
  logic [1:0]  drv_mode = 2'd0;
  logic [31:0] drv_val = '0;
  bit          keep = 1'b0;
  always @(posedge clk) begin
    drv_mode <= next_mode;
    drv_val  <= next_val;
  end
  assign sram_dq = (drv_mode == 2'd2) ? drv_val :
                   ((drv_mode == 2'd0) || keep) ? SENT : 32'hzzzz_zzzz;

  sram_mem_controller dut (
    .clk       (clk),
    .rst       (rst_n),
    .wr_en     (wr_en),
    .rd_en     (rd_en),
    .address   (address),
    .wdata     (wdata),
    .rdata     (rdata),
    .ready     (ready),
    .SRAM_WE_N (sram_we_n),
    .SRAM_ADDR (sram_addr),
    .SRAM_DQ   (sram_dq),
    .dbg_state (dbg_state)
  );

  // scoreboard
  int checks = 0;
  int failures = 0;
  logic [31:0] mem [logic [16:0]];

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic logic [31:0] mem_rd(logic [16:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction

  // model: each accepted request owns cycles t+1..t+W on the bus, then a DONE cycle unless buffered
  int          acc_lo = -100, acc_hi = -100, done_at = -100;
  bit          m_wr = 1'b0;
  logic [16:0] m_addr = '0;
  logic [31:0] m_data = '0;
  logic [31:0] m_rdata = '0;

  always @(negedge clk) begin
    bit          in_acc, in_done, idle, req, nxt_acc, e_ready;
    logic [31:0] e_dq, diff;
    if (cyc >= 1) begin
      if (!rst_n) begin
        acc_lo = -100; acc_hi = -100; done_at = -100;
        m_rdata = '0;
        next_mode = 2'd0;
      end
      if (rst_n && sram_we_n === 1'b0) mem[sram_addr] = sram_dq;
      in_acc  = (cyc >= acc_lo) && (cyc <= acc_hi);
      in_done = (cyc == done_at);
      idle    = !in_acc && !in_done;
      req     = wr_en | rd_en;
      e_ready = idle ? (!req || (BUF && wr_en)) : in_done;
      e_dq    = !in_acc ? SENT : (m_wr ? m_data : mem_rd(m_addr));
      check("ready", ready, e_ready);
      check("we_n", sram_we_n, !(in_acc && m_wr));
      check("dq", sram_dq, e_dq);
      check("rdata", rdata, m_rdata);
      if (in_acc || !rst_n) check("sram_addr", sram_addr, rst_n ? m_addr : 17'd0);
      if (rst_n) begin
        if (in_acc && cyc == acc_hi && !m_wr) m_rdata = mem_rd(m_addr);
        if (idle && req) begin
          acc_lo  = cyc + 1;
          acc_hi  = cyc + W;
          m_wr    = wr_en;
          done_at = (BUF && wr_en) ? -100 : cyc + W + 1;
          diff    = address - 32'd1024;
          m_addr  = diff[18:2];
          m_data  = wdata;
        end
        nxt_acc   = (cyc + 1 >= acc_lo) && (cyc + 1 <= acc_hi);
        next_mode = !nxt_acc ? 2'd0 : (m_wr ? 2'd1 : 2'd2);
        next_val  = mem_rd(m_addr);
      end
    end
  end

  // driver tasks
  task automatic access(input bit wr, input bit rd, input logic [31:0] a, input logic [31:0] d,
                        output int c0, output int c_rdy);
    @(posedge clk); #1;
    wr_en = wr; rd_en = rd; address = a; wdata = d;
    c0 = cyc;
    c_rdy = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (ready === 1'b1) begin
        c_rdy = cyc;
        break;
      end
    end
    if (c_rdy < 0) begin
      checks++; failures++;
      $display("FAIL ready_timeout: no ready within 40 cycles for address %h", a);
    end
  endtask

  task automatic idle_cycles(input int n);
    @(posedge clk); #1;
    wr_en = 1'b0; rd_en = 1'b0;
    repeat (n) @(posedge clk);
  endtask

  initial begin
    int c0, cr, c0b, cr2;
    mem[17'd0] = 32'h0BAD_F00D;
    mem[17'd2] = 32'hCAFE_0002;

    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("reset_ready", ready, 1);
    check("reset_we_n", sram_we_n, 1);
    check("reset_addr", sram_addr, 0);
    check("reset_rdata", rdata, 0);
    check("reset_state", dbg_state, 0);

    access(1'b1, 1'b0, 32'd1028, 32'hDEAD_BEEF, c0, cr);
    check("wr_latency", cr - c0, WR_LAT);
    idle_cycles(8);
    check("wr_mem", mem_rd(17'd1), 32'hDEAD_BEEF);

    access(1'b0, 1'b1, 32'd1028, 32'h0, c0, cr);
    check("rd_latency", cr - c0, 6);
    check("rd_data", rdata, 32'hDEAD_BEEF);
    idle_cycles(2);

    access(1'b0, 1'b1, 32'd1024, 32'h0, c0, cr);
    check("b2b_first_ready", cr - c0, 6);
    check("b2b_first_data", rdata, 32'h0BAD_F00D);
    access(1'b0, 1'b1, 32'd1032, 32'h0, c0b, cr2);
    check("b2b_second_start", c0b - c0, 7);
    check("b2b_second_ready", cr2 - c0, 13);
    check("b2b_second_addr", sram_addr, 2);
    check("b2b_second_data", rdata, 32'hCAFE_0002);
    idle_cycles(2);

    access(1'b1, 1'b1, 32'd1036, 32'h1234_5678, c0, cr);
    check("both_latency", cr - c0, WR_LAT);
    idle_cycles(8);
    check("both_mem", mem_rd(17'd3), 32'h1234_5678);
    check("both_rdata_kept", rdata, 32'hCAFE_0002);

    // address below BASE_ADDR wraps
    access(1'b1, 1'b0, 32'd0, 32'h0000_55AA, c0, cr);
    idle_cycles(8);
    check("wrap_mem", mem_rd(17'h1FF00), 32'h0000_55AA);
    access(1'b0, 1'b1, 32'd0, 32'h0, c0, cr);
    check("wrap_rd_addr", sram_addr, 17'h1FF00);
    check("wrap_rd_data", rdata, 32'h0000_55AA);
    idle_cycles(2);

    // byte-offset bits are ignored
    access(1'b0, 1'b1, 32'd1031, 32'h0, c0, cr);
    check("lowbits_addr", sram_addr, 1);
    check("lowbits_data", rdata, 32'hDEAD_BEEF);
    idle_cycles(2);

`ifdef SRAM_CTRL_WRITE_BUFFER_EN
    access(1'b1, 1'b0, 32'd1028, 32'h600D_F00D, c0, cr);
    check("buf_wr_ready", cr - c0, 0);
    access(1'b0, 1'b1, 32'd1028, 32'h0, c0b, cr2);
    check("buf_rd_start", c0b - c0, 1);
    check("buf_rd_ready", cr2 - c0, 12);
    check("buf_rd_data", rdata, 32'h600D_F00D);
    idle_cycles(2);
`endif

    // reset in ACCESS cycle 3 of a write
    @(posedge clk); #1;
    wr_en = 1'b1; rd_en = 1'b0; address = 32'd1040; wdata = 32'hA1B2_C3D4;
    repeat (3) @(posedge clk);
    #2;
    keep = 1'b1;
    rst_n = 1'b0;
    #1;
    check("midreset_we_n", sram_we_n, 1);
    check("midreset_dq", sram_dq, SENT);
    check("midreset_addr", sram_addr, 0);
    wr_en = 1'b0;
    #1;
    check("midreset_ready", ready, 1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_state", dbg_state, 0);
    check("post_reset_ready", ready, 1);
    check("post_reset_rdata", rdata, 0);
    repeat (3) @(posedge clk);
    keep = 1'b0;

    access(1'b0, 1'b1, 32'd1028, 32'h0, c0, cr);
    check("after_reset_rd_latency", cr - c0, 6);
    idle_cycles(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
